valid_ready_skid_pipeline: RTL and testbench

- Parametrised successor to the half-buffer valid/ready pipeline.
- Chains PIPELINE_DEPTH register stages between a sender and a receiver.
- A mode parameter selects half-buffer stages (one entry, half throughput) or skid stages (two entries, full throughput).
- Adds a synchronous flush and a live occupancy count, for use between CPU pipeline stages and on memory request paths.

---
 rtl/valid_ready_skid_pipeline.sv | 151 +++++++++++++++
 tb/tb_valid_ready_skid_pipeline.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/valid_ready_skid_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : valid_ready_skid_pipeline
// Purpose  : Chain of PIPELINE_DEPTH valid/ready register stages. Each stage
//            is either a two-entry skid stage (full throughput, registered
//            ready) or a single-entry half-buffer stage (half throughput).
//            Provides a synchronous flush and a live occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module valid_ready_skid_pipeline #(
  parameter int DATA_WIDTH     = 32,
  parameter int PIPELINE_DEPTH = 3,
  parameter int SKID_MODE      = 1,
  parameter int CNT_W          = $clog2(2*PIPELINE_DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      occupancy
);

  // Per-stage downstream-facing valid/data and upstream-facing ready.
  // Every one of these is driven straight from a stage register.
  logic [PIPELINE_DEPTH-1:0] w_stage_valid;
  logic [PIPELINE_DEPTH-1:0] w_up_ready;
  logic [DATA_WIDTH-1:0]     w_stage_data [PIPELINE_DEPTH];

  logic                      w_in_fire;
  logic                      w_out_fire;
  logic [CNT_W-1:0]          r_occ;

  for (genvar k = 0; k < PIPELINE_DEPTH; k++) begin : g_stage
    logic                  w_src_valid;
    logic [DATA_WIDTH-1:0] w_src_data;
    logic                  w_dst_ready;

    // The first stage sees the sender; flush blocks any entry that cycle.
    if (k == 0) begin : g_first
      assign w_src_valid = in_valid && !flush;
      assign w_src_data  = in_data;
    end else begin : g_mid
      assign w_src_valid = w_stage_valid[k-1];
      assign w_src_data  = w_stage_data[k-1];
    end

    if (k == PIPELINE_DEPTH-1) begin : g_last
      assign w_dst_ready = out_ready;
    end else begin : g_inner
      assign w_dst_ready = w_up_ready[k+1];
    end

    if (SKID_MODE != 0) begin : g_skid
      logic                  r_main_v;
      logic                  r_skid_v;
      logic [DATA_WIDTH-1:0] r_main_d;
      logic [DATA_WIDTH-1:0] r_skid_d;
      logic                  w_take;
      logic                  w_give;

      // Upstream may only push while the skid slot is free.
      assign w_take = w_src_valid && !r_skid_v;
      assign w_give = r_main_v && w_dst_ready;

      // Main/skid update: park in skid when main is stuck, refill main from skid.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_main_v <= 1'b0;
          r_skid_v <= 1'b0;
          r_main_d <= '0;
          r_skid_d <= '0;
        end else if (flush) begin
          r_main_v <= 1'b0;
          r_skid_v <= 1'b0;
        end else if (r_skid_v) begin
          if (w_give) begin
            r_main_d <= r_skid_d;
            r_skid_v <= 1'b0;
          end
        end else if (w_take) begin
          if (r_main_v && !w_give) begin
            r_skid_d <= w_src_data;
            r_skid_v <= 1'b1;
          end else begin
            r_main_d <= w_src_data;
            r_main_v <= 1'b1;
          end
        end else if (w_give) begin
          r_main_v <= 1'b0;
        end
      end

      assign w_up_ready[k]    = !r_skid_v;
      assign w_stage_valid[k] = r_main_v;
      assign w_stage_data[k]  = r_main_d;
    end else begin : g_half
      logic                  r_v;
      logic [DATA_WIDTH-1:0] r_d;

      // Single slot: load when empty, release when downstream takes it.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_v <= 1'b0;
          r_d <= '0;
        end else if (flush) begin
          r_v <= 1'b0;
        end else if (!r_v) begin
          if (w_src_valid) begin
            r_d <= w_src_data;
            r_v <= 1'b1;
          end
        end else if (w_dst_ready) begin
          r_v <= 1'b0;
        end
      end

      assign w_up_ready[k]    = !r_v;
      assign w_stage_valid[k] = r_v;
      assign w_stage_data[k]  = r_d;
    end
  end

  // External handshakes; both are suppressed during flush, in_ready also during reset.
  assign in_ready   = w_up_ready[0] && !flush && !reset;
  assign out_valid  = w_stage_valid[PIPELINE_DEPTH-1] && !flush;
  assign out_data   = w_stage_data[PIPELINE_DEPTH-1];
  assign w_in_fire  = in_valid && !flush && w_up_ready[0];
  assign w_out_fire = w_stage_valid[PIPELINE_DEPTH-1] && out_ready;

  // Item counter: +1 per accept, -1 per emit, cleared by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else if (w_in_fire && !w_out_fire) begin
      r_occ <= r_occ + CNT_W'(1);
    end else if (w_out_fire && !w_in_fire) begin
      r_occ <= r_occ - CNT_W'(1);
    end
  end

  assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_valid_ready_skid_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_valid_ready_skid_pipeline
// Purpose  : Self-checking bench for valid_ready_skid_pipeline. A skid-mode
//            and a half-buffer instance are driven against queue-based
//            reference models (FIFO order, capacity, occupancy).
// Revision : 1.0 - initial release
// ============================================================================
module tb_valid_ready_skid_pipeline;
  localparam int DEPTH    = 3;
  localparam int SKID_CAP = 2*DEPTH;
  localparam int HALF_CAP = DEPTH;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;

  logic        s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic        s_in_ready, s_out_valid;
  logic [31:0] s_in_data = '0, s_out_data;
  logic [2:0]  s_occ;

  logic        h_flush = 1'b0, h_in_valid = 1'b0, h_out_ready = 1'b0;
  logic        h_in_ready, h_out_valid;
  logic [31:0] h_in_data = '0, h_out_data;
  logic [2:0]  h_occ;

  int checks   = 0;
  int failures = 0;

  // Reference contents: everything accepted and not yet emitted, oldest first.
  logic [31:0] sq[$];
  logic [31:0] hq[$];

  always #5 clk = ~clk;

  valid_ready_skid_pipeline #(.DATA_WIDTH(32), .PIPELINE_DEPTH(DEPTH), .SKID_MODE(1)) u_skid (
    .clk(clk), .reset(reset), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occ)
  );

  valid_ready_skid_pipeline #(.DATA_WIDTH(32), .PIPELINE_DEPTH(DEPTH), .SKID_MODE(0)) u_half (
    .clk(clk), .reset(reset), .flush(h_flush),
    .in_valid(h_in_valid), .in_ready(h_in_ready), .in_data(h_in_data),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .out_data(h_out_data),
    .occupancy(h_occ)
  );

  // One cycle on the skid instance: drive at negedge, sample 1ns later, return 1ns after posedge.
  task automatic tick_s(input logic v, input logic [31:0] d, input logic r, input logic f,
                        output logic ir, output logic ov, output logic [31:0] od);
    @(negedge clk);
    s_in_valid = v; s_in_data = d; s_out_ready = r; s_flush = f;
    #1;
    ir = s_in_ready; ov = s_out_valid; od = s_out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_h(input logic v, input logic [31:0] d, input logic r,
                        output logic ir, output logic ov, output logic [31:0] od);
    @(negedge clk);
    h_in_valid = v; h_in_data = d; h_out_ready = r; h_flush = 1'b0;
    #1;
    ir = h_in_ready; ov = h_out_valid; od = h_out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (s_in_ready !== 1'b0) begin failures++; $display("FAIL reset_s_in_ready got=%b exp=0", s_in_ready); end
    checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL reset_s_out_valid got=%b exp=0", s_out_valid); end
    checks++; if (s_out_data !== 32'h0) begin failures++; $display("FAIL reset_s_out_data got=%h exp=0", s_out_data); end
    checks++; if (s_occ !== 3'd0) begin failures++; $display("FAIL reset_s_occ got=%0d exp=0", s_occ); end
    checks++; if (h_in_ready !== 1'b0) begin failures++; $display("FAIL reset_h_in_ready got=%b exp=0", h_in_ready); end
    checks++; if (h_out_valid !== 1'b0) begin failures++; $display("FAIL reset_h_out_valid got=%b exp=0", h_out_valid); end
    checks++; if (h_occ !== 3'd0) begin failures++; $display("FAIL reset_h_occ got=%0d exp=0", h_occ); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL release_s_in_ready got=%b exp=1", s_in_ready); end
    checks++; if (h_in_ready !== 1'b1) begin failures++; $display("FAIL release_h_in_ready got=%b exp=1", h_in_ready); end
  endtask

  // Stream 0x1..0x10 with the receiver always ready.
  task automatic test_stream();
    logic ir, ov, v; logic [31:0] od;
    int sent = 0, got = 0, t = 0, first_in = -1, first_out = -1;
    while ((sent < 16 || got < 16) && t < 100) begin
      v = (sent < 16);
      tick_s(v, 32'(sent + 1), 1'b1, 1'b0, ir, ov, od);
      if (v) begin
        checks++; if (ir !== 1'b1) begin failures++; $display("FAIL stream_in_ready t=%0d got=%b exp=1", t, ir); end
      end
      if (ov) begin
        checks++;
        if (sq.size() == 0) begin failures++; $display("FAIL stream_spurious t=%0d got=%h exp=none", t, od); end
        else begin
          if (od !== sq[0]) begin failures++; $display("FAIL stream_data t=%0d got=%h exp=%h", t, od, sq[0]); end
          void'(sq.pop_front());
        end
        if (first_out < 0) first_out = t;
        got++;
      end
      if (v && ir) begin
        sq.push_back(32'(sent + 1));
        if (first_in < 0) first_in = t;
        sent++;
      end
      checks++; if (s_occ !== 3'(sq.size())) begin failures++; $display("FAIL stream_occ t=%0d got=%0d exp=%0d", t, s_occ, sq.size()); end
      if (t == 8) begin
        checks++; if (s_occ !== 3'd3) begin failures++; $display("FAIL stream_steady_occ got=%0d exp=3", s_occ); end
      end
      t++;
    end
    checks++; if (got != 16) begin failures++; $display("FAIL stream_count got=%0d exp=16", got); end
    checks++; if (first_out - first_in != DEPTH) begin failures++; $display("FAIL stream_latency got=%0d exp=%0d", first_out - first_in, DEPTH); end
  endtask

  // Receiver stalled: exactly SKID_CAP accepts, then drain in order.
  task automatic test_full_stall();
    logic ir, ov; logic [31:0] od;
    int acc = 0, got = 0;
    for (int t = 0; t < 12; t++) begin
      tick_s(1'b1, 32'hA0 + 32'(acc), 1'b0, 1'b0, ir, ov, od);
      if (sq.size() == SKID_CAP) begin
        checks++; if (ir !== 1'b0) begin failures++; $display("FAIL stall_full_ready t=%0d got=%b exp=0", t, ir); end
      end
      if (ov) begin
        checks++;
        if (sq.size() == 0 || od !== sq[0]) begin failures++; $display("FAIL stall_hold_data t=%0d got=%h exp=%h", t, od, (sq.size() > 0) ? sq[0] : 32'h0); end
      end
      if (ir) begin sq.push_back(32'hA0 + 32'(acc)); acc++; end
      checks++; if (s_occ !== 3'(sq.size())) begin failures++; $display("FAIL stall_occ t=%0d got=%0d exp=%0d", t, s_occ, sq.size()); end
    end
    checks++; if (acc != SKID_CAP) begin failures++; $display("FAIL stall_accepts got=%0d exp=%0d", acc, SKID_CAP); end
    checks++; if (s_occ !== 3'd6) begin failures++; $display("FAIL stall_occ_full got=%0d exp=6", s_occ); end
    for (int t = 0; t < 30 && got < SKID_CAP; t++) begin
      tick_s(1'b0, 32'h0, 1'b1, 1'b0, ir, ov, od);
      if (ov) begin
        checks++;
        if (sq.size() == 0 || od !== sq[0]) begin failures++; $display("FAIL stall_drain_data got=%h exp=%h", od, (sq.size() > 0) ? sq[0] : 32'h0); end
        if (sq.size() > 0) void'(sq.pop_front());
        got++;
      end
    end
    checks++; if (got != SKID_CAP) begin failures++; $display("FAIL stall_drain_count got=%0d exp=%0d", got, SKID_CAP); end
  endtask

  // Half-buffer instance: at most one item every two cycles, capacity DEPTH.
  task automatic test_half();
    logic ir, ov, v, prev_in, prev_out; logic [31:0] od;
    int acc = 0, got = 0, t = 0;
    prev_in = 1'b0; prev_out = 1'b0;
    while (got < 8 && t < 40) begin
      v = (acc < 8);
      tick_h(v, 32'h30 + 32'(acc), 1'b1, ir, ov, od);
      if (v && ir) begin
        checks++; if (prev_in) begin failures++; $display("FAIL half_in_rate t=%0d got=back-to-back exp=gap", t); end
      end
      if (ov) begin
        checks++; if (prev_out) begin failures++; $display("FAIL half_out_rate t=%0d got=back-to-back exp=gap", t); end
        checks++;
        if (hq.size() == 0 || od !== hq[0]) begin failures++; $display("FAIL half_data t=%0d got=%h exp=%h", t, od, (hq.size() > 0) ? hq[0] : 32'h0); end
        if (hq.size() > 0) void'(hq.pop_front());
        got++;
      end
      if (v && ir) begin hq.push_back(32'h30 + 32'(acc)); acc++; end
      checks++; if (h_occ !== 3'(hq.size())) begin failures++; $display("FAIL half_occ t=%0d got=%0d exp=%0d", t, h_occ, hq.size()); end
      prev_in = v && ir; prev_out = ov;
      t++;
    end
    checks++; if (got != 8 || t < 16 || t > 20) begin failures++; $display("FAIL half_stream_cycles got=%0d items in %0d cycles exp=8 in 16..20", got, t); end
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      tick_h(1'b1, 32'h40 + 32'(acc), 1'b0, ir, ov, od);
      if (hq.size() == HALF_CAP) begin
        checks++; if (ir !== 1'b0) begin failures++; $display("FAIL half_full_ready got=%b exp=0", ir); end
      end
      if (ir) begin hq.push_back(32'h40 + 32'(acc)); acc++; end
    end
    checks++; if (acc != HALF_CAP) begin failures++; $display("FAIL half_accepts got=%0d exp=%0d", acc, HALF_CAP); end
    checks++; if (h_occ !== 3'd3) begin failures++; $display("FAIL half_occ_full got=%0d exp=3", h_occ); end
    got = 0;
    for (int i = 0; i < 20 && got < HALF_CAP; i++) begin
      tick_h(1'b0, 32'h0, 1'b1, ir, ov, od);
      if (ov) begin
        checks++;
        if (hq.size() == 0 || od !== hq[0]) begin failures++; $display("FAIL half_drain_data got=%h exp=%h", od, (hq.size() > 0) ? hq[0] : 32'h0); end
        if (hq.size() > 0) void'(hq.pop_front());
        got++;
      end
    end
    checks++; if (got != HALF_CAP) begin failures++; $display("FAIL half_drain_count got=%0d exp=%0d", got, HALF_CAP); end
  endtask

  // Flush with four items held and a concurrent offer of 0x99.
  task automatic test_flush();
    logic ir, ov; logic [31:0] od;
    int got = 0;
    for (int i = 0; i < 4; i++) begin
      tick_s(1'b1, 32'h11 + 32'(i), 1'b0, 1'b0, ir, ov, od);
      checks++; if (ir !== 1'b1) begin failures++; $display("FAIL flush_fill_ready i=%0d got=%b exp=1", i, ir); end
      if (ir) sq.push_back(32'h11 + 32'(i));
    end
    checks++; if (s_occ !== 3'd4) begin failures++; $display("FAIL flush_fill_occ got=%0d exp=4", s_occ); end
    tick_s(1'b1, 32'h99, 1'b1, 1'b1, ir, ov, od);
    sq.delete();
    checks++; if (ir !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", ir); end
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", ov); end
    checks++; if (s_occ !== 3'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", s_occ); end
    tick_s(1'b0, 32'h0, 1'b1, 1'b0, ir, ov, od);
    checks++; if (ir !== 1'b1) begin failures++; $display("FAIL flush_after_ready got=%b exp=1", ir); end
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL flush_after_valid got=%b exp=0", ov); end
    tick_s(1'b1, 32'h55, 1'b1, 1'b0, ir, ov, od);
    if (ir) sq.push_back(32'h55);
    for (int i = 0; i < 10; i++) begin
      tick_s(1'b0, 32'h0, 1'b1, 1'b0, ir, ov, od);
      if (ov) begin
        checks++; if (od !== 32'h55) begin failures++; $display("FAIL flush_next_out got=%h exp=55", od); end
        if (sq.size() > 0) void'(sq.pop_front());
        got++;
      end
    end
    checks++; if (got != 1) begin failures++; $display("FAIL flush_out_count got=%0d exp=1", got); end
  endtask

  // Random sender and receiver, 200 items, scoreboard every cycle.
  task automatic test_random();
    logic ir, ov, v, r; logic [31:0] od, d;
    int acc = 0, t = 0;
    while ((acc < 200 || sq.size() > 0) && t < 5000) begin
      v = (acc < 200) && ($urandom_range(0, 1) == 1);
      r = (acc >= 200) || ($urandom_range(0, 1) == 1);
      d = $urandom;
      tick_s(v, d, r, 1'b0, ir, ov, od);
      if (sq.size() == SKID_CAP) begin
        checks++; if (ir !== 1'b0) begin failures++; $display("FAIL rand_full_ready t=%0d got=%b exp=0", t, ir); end
      end
      if (sq.size() == 0) begin
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL rand_empty_valid t=%0d got=%b exp=0", t, ov); end
      end else if (ov) begin
        checks++; if (od !== sq[0]) begin failures++; $display("FAIL rand_data t=%0d got=%h exp=%h", t, od, sq[0]); end
        if (r) void'(sq.pop_front());
      end
      if (v && ir) begin sq.push_back(d); acc++; end
      checks++; if (s_occ !== 3'(sq.size())) begin failures++; $display("FAIL rand_occ t=%0d got=%0d exp=%0d", t, s_occ, sq.size()); end
      t++;
    end
    checks++; if (t >= 5000) begin failures++; $display("FAIL rand_timeout got=%0d accepted exp=200 drained", acc); end
  endtask

  // Asynchronous reset with five items held.
  task automatic test_async_reset();
    logic ir, ov; logic [31:0] od;
    for (int i = 0; i < 5; i++) begin
      tick_s(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0, ir, ov, od);
      if (ir) sq.push_back(32'hC0 + 32'(i));
    end
    checks++; if (s_occ !== 3'd5) begin failures++; $display("FAIL areset_fill_occ got=%0d exp=5", s_occ); end
    #2;
    s_in_valid = 1'b0; s_out_ready = 1'b1;
    reset = 1'b1;
    #1;
    sq.delete();
    checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL areset_out_valid got=%b exp=0", s_out_valid); end
    checks++; if (s_out_data !== 32'h0) begin failures++; $display("FAIL areset_out_data got=%h exp=0", s_out_data); end
    checks++; if (s_occ !== 3'd0) begin failures++; $display("FAIL areset_occ got=%0d exp=0", s_occ); end
    checks++; if (s_in_ready !== 1'b0) begin failures++; $display("FAIL areset_in_ready got=%b exp=0", s_in_ready); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL areset_release_ready got=%b exp=1", s_in_ready); end
    checks++; if (s_occ !== 3'd0) begin failures++; $display("FAIL areset_release_occ got=%0d exp=0", s_occ); end
    for (int i = 0; i < 8; i++) begin
      tick_s(1'b0, 32'h0, 1'b1, 1'b0, ir, ov, od);
      checks++; if (ov !== 1'b0) begin failures++; $display("FAIL areset_stale i=%0d got=%h exp=none", i, od); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full_stall();
    test_half();
    test_flush();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
